// File: rtl/regfile_read_arbiter_pkg.sv
// Shared definitions for the register-file read arbiter: scan FSM states,
// register-file geometry and the slot-index width helper.
package regfile_read_arbiter_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Width needed to encode nreq external slots plus the scan slot.
  function automatic int slot_w(input int nreq);
    return (nreq < 1) ? 1 : $clog2(nreq + 1);
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester-side bus of the register-file read arbiter.
//
// Handshake: req[i] is a level request held until gnt[i] pulses in the same
// cycle (gnt is combinational on req). In the cycle after gnt[i] the requester
// may change addr or drop req. Exactly two cycles after gnt[i], rvalid[i] is
// high for one cycle and rdata carries the entry; there is no back-pressure.
interface regfile_read_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
);
  import regfile_read_arbiter_pkg::*;

  logic [NREQ-1:0]           req;
  logic [NREQ*REG_IDX_W-1:0] addr;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           rvalid;
  logic [N-1:0]              rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin arbiter over WIDTH slots. The search starts at ptr; the first
// requesting slot wins. After a grant the pointer moves one past the winner.
module rr_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int PW    = slot_w(WIDTH - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             advance,
  output logic [WIDTH-1:0] gnt,
  output logic [PW-1:0]    winner,
  output logic [PW-1:0]    ptr
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Rotating priority search starting at the pointer, wrapping at WIDTH.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum = {1'b0, ptr} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(WIDTH)) begin
        sum = sum - (PW + 1)'(WIDTH);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = idx;
      end
    end
  end

  // Pointer moves past the winner on a grant and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      if (winner == PW'(WIDTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= winner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one 32-entry read mux between NREQ requesters and a scan engine.
// Grant cycle t registers the mux select, cycle t+1 captures the mux output,
// and the result is flagged valid in cycle t+2 for the winning slot.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  localparam int SW  = slot_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_read_arbiter_if.slave bus,
  output logic [REG_IDX_W-1:0] mux_sel,
  input  logic [N-1:0]         mux_out,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic                 scan_valid,
  output logic [REG_IDX_W-1:0] scan_idx,
  output logic                 scan_done,
  output logic [1:0]           scan_state,
  output logic [SW-1:0]        rr_ptr
);

  localparam int SLOTS = NREQ + 1;
  localparam logic [SW-1:0] SCAN_SLOT = SW'(NREQ);
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_SCAN = 2'(SCAN);
  localparam logic [1:0] ST_DONE = 2'(DONE);
  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(REG_COUNT - 1);

  logic [1:0]           state;
  logic [REG_IDX_W-1:0] scan_cnt;
  logic [SLOTS-1:0]     slot_req;
  logic [SLOTS-1:0]     slot_gnt;
  logic [SW-1:0]        winner;
  logic                 any_gnt;
  logic [REG_IDX_W-1:0] win_idx;
  logic                 tag_valid;
  logic [SW-1:0]        tag;

  // Scan slot sits above the external slots; nothing competes during reset.
  assign slot_req = rst ? '0 : {(state == ST_SCAN), bus.req};

  rr_arbiter #(
    .WIDTH (SLOTS),
    .PW    (SW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (slot_req),
    .advance (!rst),
    .gnt     (slot_gnt),
    .winner  (winner),
    .ptr     (rr_ptr)
  );

  assign any_gnt = |slot_gnt;
  assign bus.gnt = slot_gnt[NREQ-1:0];

  // Entry index requested by the winning slot (scan slot uses its counter).
  always_comb begin
    win_idx = scan_cnt;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == SW'(i)) begin
        win_idx = bus.addr[i*REG_IDX_W +: REG_IDX_W];
      end
    end
  end

  // Issue stage: register the mux select and remember who it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_sel   <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
    end else if (any_gnt) begin
      mux_sel   <= win_idx;
      tag       <= winner;
      tag_valid <= 1'b1;
    end else begin
      tag_valid <= 1'b0;
    end
  end

  // Capture stage: latch the mux output and raise exactly one valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata  <= '0;
      bus.rvalid <= '0;
      scan_valid <= 1'b0;
      scan_idx   <= '0;
    end else begin
      bus.rvalid <= '0;
      scan_valid <= 1'b0;
      if (tag_valid) begin
        bus.rdata <= mux_out;
        if (tag == SCAN_SLOT) begin
          scan_valid <= 1'b1;
          scan_idx   <= mux_sel;
        end else begin
          for (int i = 0; i < NREQ; i++) begin
            if (tag == SW'(i)) begin
              bus.rvalid[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Scan FSM: walk entries 0..31 once per start, one entry per scan grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      scan_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (scan_start) begin
            state    <= ST_SCAN;
            scan_cnt <= '0;
          end
        end
        ST_SCAN: begin
          if (slot_gnt[NREQ]) begin
            if (scan_cnt == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              scan_cnt <= scan_cnt + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign scan_state = state;
  assign scan_busy  = (state != ST_IDLE);
  assign scan_done  = (state == ST_DONE) && !rst;

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

- Shares the single 32-entry, N-bit read multiplexer between NREQ requesters plus an internal scan engine.
- Arbitrates round-robin, registers the 5-bit select that drives the mux, and captures the mux output one cycle later.
- Returns the captured data with a per-requester valid and a 2-cycle fixed latency.
- The scan engine walks all 32 entries in index order for debug/dump.

## Interface
Parameters:
- N, 8, data width (matches mux width)
- NREQ, 4, number of external requesters (1..8)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- req  in  NREQ  request per requester; held until granted
- addr  in  NREQ*5  entry index per requester; slice i = addr[5i+4:5i]
- gnt  out  NREQ  grant pulse, combinational in request cycle
- rvalid  out  NREQ  one-hot; data for requester i present on rdata
- rdata  out  N  captured read data, shared by all consumers
- mux_sel  out  5  registered select to the mux
- mux_out  in  N  combinational mux output
- scan_start  in  1  pulse; begin a full 32-entry scan
- scan_busy  out  1  high while scan FSM is not IDLE
- scan_valid  out  1  rdata holds a scan result
- scan_idx  out  5  entry index of the scan result on rdata
- scan_done  out  1  one-cycle pulse after the last scan read issues

## Operation
- Slots 0..NREQ-1 are external requesters. Slot NREQ is the scan engine; it requests whenever in SCAN.
- Arbitration:
  - Round-robin pointer rr_ptr over NREQ+1 slots.
  - Search starts at rr_ptr; the first requesting slot wins; at most one gnt per cycle.
  - On any grant, rr_ptr <= winner+1, wrapping NREQ -> 0. With no grant, rr_ptr holds.
- Issue (grant cycle t): mux_sel <= winner's index; tag register <= winner slot, tag_valid <= 1. With no grant, tag_valid <= 0 and mux_sel holds.
- Capture (cycle t+1): if tag_valid, rdata <= mux_out.
  - Slot i < NREQ: rvalid[i] <= 1.
  - Scan slot: scan_valid <= 1 and scan_idx <= issued index.
  - All other valids <= 0.
- rdata holds its last value when nothing is captured.
- Requester handshake:
  - A requester seeing gnt[i]=1 may change addr or drop req the next cycle.
  - A requester keeping req high competes again and is granted at most once per NREQ+1 cycles under full load.
- Scan FSM, states IDLE, SCAN, DONE:
  - IDLE: scan_start -> SCAN, scan counter <= 0.
  - SCAN: requests with index = counter. Each scan grant does counter++. A grant at counter=31 -> DONE (no wrap to 0 issued).
  - DONE: scan_done=1 for this cycle -> IDLE.
  - scan_start is ignored in SCAN and DONE.
  - The scan may be interleaved with external grants per round-robin; result order is always 0..31.

## Timing
- Latency: gnt in cycle t -> mux_sel valid in t+1 -> rvalid/scan_valid high in cycle t+2, exactly one cycle per grant.
- Throughput: one read per cycle, fully pipelined; back-to-back grants give back-to-back valids.
- Reset values: mux_sel=0, rr_ptr=0, tag_valid=0, rdata=0, rvalid=0, scan_valid=0, scan_idx=0, scan_done=0, scan_busy=0, FSM=IDLE, counter=0.
- Reset mid-operation:
  - In-flight tags are discarded; no valid is asserted in the cycles after rst.
  - A scan in progress is aborted without scan_done.
- gnt is forced to 0 while rst=1.
- Simultaneous scan_start and scan completion are covered by the rule that scan_start is ignored outside IDLE.

## Structure
- Shared package holds:
  - scan state enum {IDLE, SCAN, DONE}
  - constant REG_COUNT=32 and REG_IDX_W=5
  - slot-index width function clog2(NREQ+1)
- Sub-module rr_arbiter (parameter WIDTH=NREQ+1):
  - inputs: req vector, advance enable
  - outputs: one-hot grant, encoded winner, internal pointer
- The issue/capture pipeline and scan FSM live in the top module.

## Test plan
- Single request: req[0]=1, addr0=5, mux model returns entry*3 -> gnt[0] in cycle t, mux_sel=5 at t+1, rvalid[0]=1 and rdata=15 at t+2.
- Contention: req[0..3] all high from reset -> grants 0,1,2,3 on consecutive cycles; then 0 again only after the idle scan slot is skipped; each rvalid two cycles after its gnt.
- Back-to-back: req[2] held 4 cycles with addr 1,2,3,4 -> four consecutive rvalid[2] with rdata 3,6,9,12.
- Full scan: scan_start, no external reqs -> 32 scan_valid with scan_idx 0..31; scan_done one cycle after index 31 issues; scan_busy falls afterward.
- Scan under load: req[1] constantly high during a scan -> grants alternate slot 1 / scan; scan_idx still strictly 0..31.
- Reset mid-scan: rst for one cycle at scan index 10 -> all valids 0 afterward, scan_busy=0, no scan_done; a new scan_start restarts at index 0.
